// File: rtl/dwt2d_haar_tile.sv
// Streaming single-level 2D Haar DWT over NxN tiles: horizontal pass on row entry,
// vertical pass combinationally from the tile buffer while draining coefficient rows.
module dwt2d_haar_tile #(
  parameter int N     = 8,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*PIX_W-1:0]       in_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*(PIX_W+3)-1:0]   out_row,
  output logic                     out_last
);

  localparam int ROW_W  = PIX_W + 2;
  localparam int COEF_W = PIX_W + 3;
  localparam int CNT_W  = $clog2(N);
  localparam int HALF   = N / 2;

  typedef enum logic {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_cnt_last;
  logic                    w_accept;
  logic                    w_vert;
  logic [CNT_W-1:0]        w_pair;
  logic [CNT_W-1:0]        w_row_a;
  logic [CNT_W-1:0]        w_row_b;
  logic signed [ROW_W-1:0] w_row_tf [N];
  logic signed [ROW_W-1:0] r_buf [N][N];

  assign w_cnt_last = (r_cnt == CNT_W'(N - 1));
  assign w_accept   = in_ready & in_valid;

  // State register and shared row counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: counter wraps naturally since N is a power of two
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_FILL: begin
        if (in_valid) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = w_cnt_last ? ST_DRAIN : ST_FILL;
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = w_cnt_last ? ST_FILL : ST_DRAIN;
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Handshake outputs depend on registered state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (r_state)
      ST_FILL:  in_ready = 1'b1;
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_cnt_last;
      end
      default:  in_ready = 1'b0;
    endcase
  end

  // Horizontal pass: L in the low half, H in the high half of the row
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_row_tf[k] = '0;
    end
    for (int k = 0; k < HALF; k++) begin
      w_row_tf[k]        = ROW_W'(in_row[2*k*PIX_W +: PIX_W]) + ROW_W'(in_row[(2*k+1)*PIX_W +: PIX_W]);
      w_row_tf[k + HALF] = ROW_W'(in_row[2*k*PIX_W +: PIX_W]) - ROW_W'(in_row[(2*k+1)*PIX_W +: PIX_W]);
    end
  end

  // Tile buffer has no reset; rows are always written before being read
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_cnt] <= w_row_tf;
    end
  end

  // Vertical pass: upper output rows sum a row pair, lower rows take its difference
  always_comb begin
    w_vert  = (r_cnt >= CNT_W'(HALF));
    w_pair  = w_vert ? (r_cnt - CNT_W'(HALF)) : r_cnt;
    w_row_a = w_pair << 1'b1;
    w_row_b = w_row_a | CNT_W'(1);
    out_row = '0;
    for (int s = 0; s < N; s++) begin
      if (w_vert) begin
        out_row[s*COEF_W +: COEF_W] = COEF_W'(r_buf[w_row_a][s]) - COEF_W'(r_buf[w_row_b][s]);
      end else begin
        out_row[s*COEF_W +: COEF_W] = COEF_W'(r_buf[w_row_a][s]) + COEF_W'(r_buf[w_row_b][s]);
      end
    end
  end

endmodule

// File: tb/tb_dwt2d_haar_tile.sv
// Bench for dwt2d_haar_tile: fixed patterns, backpressure, async reset and randomized
// streaming against a direct 2x2-block Haar reference, on an 8x8/8-bit and a 4x4/12-bit instance.
module tb_dwt2d_haar_tile;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [63:0] in_row;
  logic [87:0] out_row;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [47:0] in_row2;
  logic [59:0] out_row2;

  int errors = 0;
  int checks = 0;
  int pix[8][8];

  dwt2d_haar_tile #(.N(8), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last)
  );

  dwt2d_haar_tile #(.N(4), .PIX_W(12)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_row(in_row2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_row(out_row2), .out_last(out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each coefficient is a signed sum over one 2x2 pixel block
  function automatic int haar_ref(input int n, input int j, input int s);
    int half, i, k, acc, sg;
    bit vert, horz;
    half = n / 2;
    vert = (j >= half);
    horz = (s >= half);
    i = vert ? j - half : j;
    k = horz ? s - half : s;
    acc = 0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        sg = 1;
        if (vert && dr == 1) sg = -sg;
        if (horz && dc == 1) sg = -sg;
        acc += sg * pix[2*i + dr][2*k + dc];
      end
    end
    return acc;
  endfunction

  function automatic logic [87:0] exp8(input int j);
    logic [87:0] e;
    e = '0;
    for (int s = 0; s < 8; s++) e[s*11 +: 11] = 11'(haar_ref(8, j, s));
    return e;
  endfunction

  function automatic logic [59:0] exp4(input int j);
    logic [59:0] e;
    e = '0;
    for (int s = 0; s < 4; s++) e[s*15 +: 15] = 15'(haar_ref(4, j, s));
    return e;
  endfunction

  function automatic logic [63:0] pack8(input int r);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(pix[r][c]);
    return v;
  endfunction

  function automatic logic [47:0] pack4(input int r);
    logic [47:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c*12 +: 12] = 12'(pix[r][c]);
    return v;
  endfunction

  function automatic int coef8(input logic [87:0] v, input int s);
    logic signed [10:0] t;
    t = v[s*11 +: 11];
    return int'(t);
  endfunction

  task automatic gen_tile(input int n, input int maxv);
    int v;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 1) ? maxv : 0;
        else v = int'($urandom_range(0, maxv));
        pix[r][c] = v;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; in_row2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_n4: got %b expected 1", in_ready2); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_n4: got %b expected 0", out_valid2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // kind 0 = flat 100, 1 = ramp p=c, 2 = full-scale checkerboard
  task automatic test_pattern(input int kind);
    int c0[3];
    int c04[3];
    int c44[3];
    c0  = '{400, 2, 510};
    c04 = '{0, -2, 0};
    c44 = '{0, 0, 510};
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (kind)
          0: pix[r][c] = 100;
          1: pix[r][c] = c;
          default: pix[r][c] = ((r + c) % 2 == 0) ? 255 : 0;
        endcase
      end
    end
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      in_row = pack8(r);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pat%0d_fill_ready r%0d: got %b expected 1", kind, r, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pat%0d_valid j%0d: got %b expected 1", kind, j, out_valid); end
      checks++; if (out_row !== exp8(j)) begin errors++; $display("FAIL pat%0d_row%0d: got %h expected %h", kind, j, out_row, exp8(j)); end
      checks++; if (out_last !== 1'(j == 7)) begin errors++; $display("FAIL pat%0d_last j%0d: got %b expected %b", kind, j, out_last, (j == 7)); end
      if (j == 0) begin
        checks++; if (coef8(out_row, 0) != c0[kind]) begin errors++; $display("FAIL pat%0d_r0c0: got %0d expected %0d", kind, coef8(out_row, 0), c0[kind]); end
        checks++; if (coef8(out_row, 4) != c04[kind]) begin errors++; $display("FAIL pat%0d_r0c4: got %0d expected %0d", kind, coef8(out_row, 4), c04[kind]); end
      end
      if (j == 4) begin
        checks++; if (coef8(out_row, 4) != c44[kind]) begin errors++; $display("FAIL pat%0d_r4c4: got %0d expected %0d", kind, coef8(out_row, 4), c44[kind]); end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL pat%0d_refill: got valid=%b ready=%b expected 0/1", kind, out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    gen_tile(8, 255);
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      in_row = pack8(r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_row = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
          checks++; if (out_row !== exp8(2)) begin errors++; $display("FAIL bp_hold k%0d: got %h expected %h", k, out_row, exp8(2)); end
          checks++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL bp_flags k%0d: got valid=%b last=%b expected 1/0", k, out_valid, out_last); end
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready k%0d: got %b expected 0", k, in_ready); end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      checks++; if (out_row !== exp8(j)) begin errors++; $display("FAIL bp_row%0d: got %h expected %h", j, out_row, exp8(j)); end
      checks++; if (out_last !== 1'(j == 7)) begin errors++; $display("FAIL bp_last j%0d: got %b expected %b", j, out_last, (j == 7)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_refill: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_fill();
    gen_tile(8, 255);
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1;
      in_row = pack8(r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstfill_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfill_out_valid: got %b expected 0", out_valid); end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    gen_tile(8, 255);
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      in_row = pack8(r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstdrain_pre_valid: got %b expected 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdrain_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstdrain_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstdrain_out_last: got %b expected 0", out_last); end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic stream_n8(input int ntiles, input bit rnd);
    int fr, dr, done, last_cyc, budget;
    bit draining;
    gen_tile(8, 255);
    fr = 0; dr = 0; done = 0; draining = 1'b0; last_cyc = -1;
    budget = ntiles * 16 * 8 + 100;
    for (int cyc = 0; cyc < budget && done < ntiles; cyc++) begin
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_row = pack8(fr);
      checks++; if (in_ready !== ~draining) begin errors++; $display("FAIL s8_in_ready cyc%0d: got %b expected %b", cyc, in_ready, ~draining); end
      checks++; if (out_valid !== draining) begin errors++; $display("FAIL s8_out_valid cyc%0d: got %b expected %b", cyc, out_valid, draining); end
      if (draining) begin
        checks++; if (out_row !== exp8(dr)) begin errors++; $display("FAIL s8_row tile%0d row%0d: got %h expected %h", done, dr, out_row, exp8(dr)); end
        checks++; if (out_last !== 1'(dr == 7)) begin errors++; $display("FAIL s8_last tile%0d row%0d: got %b expected %b", done, dr, out_last, (dr == 7)); end
        if (out_last === 1'b1) begin
          if (!rnd && last_cyc >= 0) begin
            checks++; if (cyc - last_cyc != 16) begin errors++; $display("FAIL s8_last_period: got %0d expected 16", cyc - last_cyc); end
          end
          last_cyc = cyc;
        end
        if (out_ready) begin
          if (dr == 7) begin dr = 0; draining = 1'b0; done++; gen_tile(8, 255); end
          else dr++;
        end
      end else begin
        if (in_valid) begin
          if (fr == 7) begin fr = 0; draining = 1'b1; end
          else fr++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (done != ntiles) begin errors++; $display("FAIL s8_timeout: got %0d tiles expected %0d", done, ntiles); end
  endtask

  task automatic stream_n4(input int ntiles, input bit rnd);
    int fr, dr, done, last_cyc, budget;
    bit draining;
    gen_tile(4, 4095);
    fr = 0; dr = 0; done = 0; draining = 1'b0; last_cyc = -1;
    budget = ntiles * 8 * 8 + 100;
    for (int cyc = 0; cyc < budget && done < ntiles; cyc++) begin
      in_valid2  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready2 = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_row2 = pack4(fr);
      checks++; if (in_ready2 !== ~draining) begin errors++; $display("FAIL s4_in_ready cyc%0d: got %b expected %b", cyc, in_ready2, ~draining); end
      checks++; if (out_valid2 !== draining) begin errors++; $display("FAIL s4_out_valid cyc%0d: got %b expected %b", cyc, out_valid2, draining); end
      if (draining) begin
        checks++; if (out_row2 !== exp4(dr)) begin errors++; $display("FAIL s4_row tile%0d row%0d: got %h expected %h", done, dr, out_row2, exp4(dr)); end
        checks++; if (out_last2 !== 1'(dr == 3)) begin errors++; $display("FAIL s4_last tile%0d row%0d: got %b expected %b", done, dr, out_last2, (dr == 3)); end
        if (out_last2 === 1'b1) begin
          if (!rnd && last_cyc >= 0) begin
            checks++; if (cyc - last_cyc != 8) begin errors++; $display("FAIL s4_last_period: got %0d expected 8", cyc - last_cyc); end
          end
          last_cyc = cyc;
        end
        if (out_ready2) begin
          if (dr == 3) begin dr = 0; draining = 1'b0; done++; gen_tile(4, 4095); end
          else dr++;
        end
      end else begin
        if (in_valid2) begin
          if (fr == 3) begin fr = 0; draining = 1'b1; end
          else fr++;
        end
      end
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
    checks++; if (done != ntiles) begin errors++; $display("FAIL s4_timeout: got %0d tiles expected %0d", done, ntiles); end
  endtask

  task automatic test_back_to_back();
    stream_n8(3, 1'b0);
    stream_n4(3, 1'b0);
  endtask

  task automatic test_random();
    stream_n8(100, 1'b1);
    stream_n4(100, 1'b1);
  endtask

  initial begin
    test_reset();
    test_pattern(0);
    test_pattern(1);
    test_pattern(2);
    test_backpressure();
    test_reset_mid_fill();
    test_pattern(0);
    test_reset_mid_drain();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
